cpu_control_fsm: RTL
====================

Name: cpu_control_fsm

Overview:
Multi-cycle sequencer for the 8-bit softcore: fetch -> decode -> execute -> memory -> writeback.
- Drives the instruction/data memory handshakes, IR load, PC update, register write-enable and writeback select.
- Consumes the one-hot instruction_en vector from instruction_decoder and the compare flags from the datapath.
- Counts retired instructions.

Parameters:
PC_WIDTH, 8, width of retired-count wrap reference (unused arithmetically; documents PC domain)
RETIRE_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instruction_en  in  ISA_INSTRUCTION_COUNT  one-hot decoded instruction (combinational from IR)
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
flag_lt  in  1  datapath compare: A < B
flag_gt  in  1  datapath compare: A > B
flag_eq  in  1  datapath compare: A == B
imem_req  out  1  instruction fetch request
ir_load  out  1  latch instruction register
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= target
pc_sel  out  1  target select: 0 = register value, 1 = PC-relative imm
exec_en  out  1  datapath performs decoded ALU/copy op this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (SB)
reg_we  out  1  register-file write
wb_sel  out  2  00 ALU result, 01 load data, 10 PC
state_o  out  3  current state (debug)
retired  out  RETIRE_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=IDLE, retired=0, all outputs 0. Applies at any time, including mid-handshake; in-flight requests drop immediately.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Outputs are Moore-decoded from state, except ir_load, pc_inc and branch/jump signals, which are qualified by the same-cycle inputs.
- IDLE: -> FETCH next cycle.
- FETCH: imem_req=1, held until imem_ack. On an imem_ack cycle: ir_load=1, pc_inc=1, -> DECODE. imem_ack in any other state is ignored.
- DECODE: one settle cycle, no outputs -> EXEC.
- EXEC, classification by instruction_en:
  - ADD, ADDI, SH, SHI, NOT, AND, OR, XOR, CPY, CPYPC: exec_en=1 -> WB.
  - LB, SB: -> MEM.
  - JMPADR: pc_load=1, pc_sel=0 -> FETCH, retire.
  - JMPI: pc_load=1, pc_sel=1 -> FETCH, retire.
  - BLT/BGT/BEQ/BNEQ: condition is flag_lt / flag_gt / flag_eq / !flag_eq. Taken: pc_load=1, pc_sel=1. Not taken: no PC change. Either way -> FETCH, retire.
  - All-zero vector: NOP, -> FETCH, retire.
  - Multiple bits set: lowest ISA index wins.
- MEM: dmem_req=1, dmem_we=SB; instruction class is registered on EXEC exit. Held until dmem_ack. On ack: LB -> WB; SB -> FETCH, retire.
- WB: reg_we=1 for one cycle. wb_sel=10 for CPYPC, 01 for LB, else 00. -> FETCH, retire.
- Latency, with ack in the first request cycle:
  - ALU/copy: 4 cycles.
  - Jump/branch: 3 cycles.
  - SB: 4 cycles.
  - LB: 5 cycles.
- retired increments by 1 on the cycle the FSM leaves an instruction's final state. Wraps modulo 2^RETIRE_W.
- Illegal state encoding -> IDLE.

Optional Feature:
CPU_DEBUG_STEP_EN
- Defined: adds inputs dbg_halt and dbg_step.
  - While dbg_halt=1, the FSM finishes the current instruction, then parks in IDLE instead of entering FETCH.
  - A dbg_step single-cycle pulse while parked allows exactly one instruction, after which the FSM parks again.
  - dbg_step while not parked is ignored.
- Undefined: ports absent; IDLE always proceeds to FETCH.

Decomposition:
- Shared package/include (isa_defs):
  - ISA_INSTRUCTION_COUNT and all ISA_* bit indices.
  - State encodings CTL_IDLE..CTL_WB.
  - WB_SEL_ALU/MEM/PC constants.
- Natural sub-module branch_resolve: combinational; instruction_en + flags -> {is_branch, taken}.

Test Plan:
- ADD one-hot, imem_ack on first request cycle -> ir_load/pc_inc in cycle 1, exec_en cycle 3, reg_we with wb_sel=00 cycle 4, retired 0->1.
- LB with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then reg_we with wb_sel=01; SB with same delay -> dmem_we=1, no reg_we, retired +1.
- BEQ: flag_eq=1 -> pc_load=1, pc_sel=1. BNEQ with flag_eq=1 -> pc_load=0. Each returns to FETCH in 3 cycles.
- CPYPC -> wb_sel=10 on reg_we cycle; JMPADR -> pc_load=1, pc_sel=0; all-zero vector -> no exec_en/reg_we, retired still +1.
- rst_n low mid-MEM with dmem_req=1 -> dmem_req drops asynchronously, state_o=0, retired=0; FETCH resumes one cycle after release.
- CPU_DEBUG_STEP_EN: dbg_halt=1 during EXEC -> completes, parks in IDLE; one dbg_step pulse -> exactly one retire, then parked again.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// Shared ISA bit indices, sequencer state encodings and writeback-select codes
// for the 8-bit softcore control path.
package cpu_control_fsm_pkg;

    localparam int unsigned ISA_INSTRUCTION_COUNT = 18;

    localparam int unsigned ISA_ADD    = 0;
    localparam int unsigned ISA_ADDI   = 1;
    localparam int unsigned ISA_SH     = 2;
    localparam int unsigned ISA_SHI    = 3;
    localparam int unsigned ISA_NOT    = 4;
    localparam int unsigned ISA_AND    = 5;
    localparam int unsigned ISA_OR     = 6;
    localparam int unsigned ISA_XOR    = 7;
    localparam int unsigned ISA_CPY    = 8;
    localparam int unsigned ISA_CPYPC  = 9;
    localparam int unsigned ISA_LB     = 10;
    localparam int unsigned ISA_SB     = 11;
    localparam int unsigned ISA_JMPADR = 12;
    localparam int unsigned ISA_JMPI   = 13;
    localparam int unsigned ISA_BLT    = 14;
    localparam int unsigned ISA_BGT    = 15;
    localparam int unsigned ISA_BEQ    = 16;
    localparam int unsigned ISA_BNEQ   = 17;

    typedef enum logic [2:0] {
        CTL_IDLE   = 3'd0,
        CTL_FETCH  = 3'd1,
        CTL_DECODE = 3'd2,
        CTL_EXEC   = 3'd3,
        CTL_MEM    = 3'd4,
        CTL_WB     = 3'd5
    } ctl_state_e;

    // Instruction class that must survive past EXEC (MEM direction, WB source).
    typedef enum logic [1:0] {
        CLS_ALU   = 2'd0,
        CLS_CPYPC = 2'd1,
        CLS_LB    = 2'd2,
        CLS_SB    = 2'd3
    } ctl_cls_e;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC  = 2'b10;

    // Keeps only the lowest set bit, so the lowest ISA index wins on a malformed vector.
    function automatic logic [ISA_INSTRUCTION_COUNT-1:0] isolate_lowest(
        input logic [ISA_INSTRUCTION_COUNT-1:0] v
    );
        return v & (-v);
    endfunction

endpackage

// File: rtl/cpu_control_fsm_branch_resolve.sv
// Combinational branch classification: flags whether the (one-hot) instruction is a
// conditional branch and whether its compare condition holds.
module cpu_control_fsm_branch_resolve
    import cpu_control_fsm_pkg::*;
(
    input  logic [ISA_INSTRUCTION_COUNT-1:0] i_instr,
    input  logic                             i_flag_lt,
    input  logic                             i_flag_gt,
    input  logic                             i_flag_eq,
    output logic                             o_is_branch,
    output logic                             o_taken
);

    always_comb begin
        o_is_branch = i_instr[ISA_BLT] | i_instr[ISA_BGT] | i_instr[ISA_BEQ] | i_instr[ISA_BNEQ];
        o_taken     = (i_instr[ISA_BLT]  &  i_flag_lt) |
                      (i_instr[ISA_BGT]  &  i_flag_gt) |
                      (i_instr[ISA_BEQ]  &  i_flag_eq) |
                      (i_instr[ISA_BNEQ] & ~i_flag_eq);
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 8-bit softcore.
// Optional halt/single-step debug control is built when CPU_DEBUG_STEP_EN is defined.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ISA_INSTRUCTION_COUNT-1:0] instruction_en,
    input  logic                             imem_ack,
    input  logic                             dmem_ack,
    input  logic                             flag_lt,
    input  logic                             flag_gt,
    input  logic                             flag_eq,
`ifdef CPU_DEBUG_STEP_EN
    input  logic                             dbg_halt,
    input  logic                             dbg_step,
`endif
    output logic                             imem_req,
    output logic                             ir_load,
    output logic                             pc_inc,
    output logic                             pc_load,
    output logic                             pc_sel,
    output logic                             exec_en,
    output logic                             dmem_req,
    output logic                             dmem_we,
    output logic                             reg_we,
    output logic [1:0]                       wb_sel,
    output logic [2:0]                       state_o,
    output logic [RETIRE_W-1:0]              retired
);

    if (PC_WIDTH == 0) begin : g_bad_pc_width
        $error("PC_WIDTH must be nonzero");
    end

    ctl_state_e                       r_state, w_state_d, w_resume;
    ctl_cls_e                         r_cls, w_cls_dec, w_cls_d;
    logic [ISA_INSTRUCTION_COUNT-1:0] w_instr;
    logic                             w_is_alu, w_is_cpypc, w_is_lb, w_is_sb;
    logic                             w_is_jmpadr, w_is_jmpi, w_is_branch, w_taken;
    logic                             w_start, w_retire;
    logic                             r_imem_req, r_dmem_req, r_dmem_we, r_reg_we;
    logic [1:0]                       r_wb_sel;
    logic [RETIRE_W-1:0]              r_retired;

    assign w_instr     = isolate_lowest(instruction_en);
    assign w_is_alu    = w_instr[ISA_ADD] | w_instr[ISA_ADDI] | w_instr[ISA_SH] |
                         w_instr[ISA_SHI] | w_instr[ISA_NOT] | w_instr[ISA_AND] |
                         w_instr[ISA_OR] | w_instr[ISA_XOR] | w_instr[ISA_CPY];
    assign w_is_cpypc  = w_instr[ISA_CPYPC];
    assign w_is_lb     = w_instr[ISA_LB];
    assign w_is_sb     = w_instr[ISA_SB];
    assign w_is_jmpadr = w_instr[ISA_JMPADR];
    assign w_is_jmpi   = w_instr[ISA_JMPI];

    cpu_control_fsm_branch_resolve u_branch_resolve (
        .i_instr     (w_instr),
        .i_flag_lt   (flag_lt),
        .i_flag_gt   (flag_gt),
        .i_flag_eq   (flag_eq),
        .o_is_branch (w_is_branch),
        .o_taken     (w_taken)
    );

`ifdef CPU_DEBUG_STEP_EN
    // Halt takes effect at instruction boundaries; a step pulse releases one instruction.
    assign w_start  = !dbg_halt || dbg_step;
    assign w_resume = dbg_halt ? CTL_IDLE : CTL_FETCH;
`else
    assign w_start  = 1'b1;
    assign w_resume = CTL_FETCH;
`endif

    always_comb begin
        if (w_is_lb)         w_cls_dec = CLS_LB;
        else if (w_is_sb)    w_cls_dec = CLS_SB;
        else if (w_is_cpypc) w_cls_dec = CLS_CPYPC;
        else                 w_cls_dec = CLS_ALU;
        w_cls_d = (r_state == CTL_EXEC) ? w_cls_dec : r_cls;
    end

    always_comb begin
        w_state_d = r_state;
        w_retire  = 1'b0;
        case (r_state)
            CTL_IDLE:   if (w_start) w_state_d = CTL_FETCH;
            CTL_FETCH:  if (imem_ack) w_state_d = CTL_DECODE;
            CTL_DECODE: w_state_d = CTL_EXEC;
            CTL_EXEC: begin
                if (w_is_alu || w_is_cpypc) begin
                    w_state_d = CTL_WB;
                end else if (w_is_lb || w_is_sb) begin
                    w_state_d = CTL_MEM;
                end else begin
                    w_state_d = w_resume;
                    w_retire  = 1'b1;
                end
            end
            CTL_MEM: begin
                if (dmem_ack) begin
                    if (r_cls == CLS_LB) begin
                        w_state_d = CTL_WB;
                    end else begin
                        w_state_d = w_resume;
                        w_retire  = 1'b1;
                    end
                end
            end
            CTL_WB: begin
                w_state_d = w_resume;
                w_retire  = 1'b1;
            end
            default:    w_state_d = CTL_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CTL_IDLE;
            r_cls      <= CLS_ALU;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_reg_we   <= 1'b0;
            r_wb_sel   <= WB_SEL_ALU;
            r_retired  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cls      <= w_cls_d;
            r_imem_req <= (w_state_d == CTL_FETCH);
            r_dmem_req <= (w_state_d == CTL_MEM);
            r_dmem_we  <= (w_state_d == CTL_MEM) && (w_cls_d == CLS_SB);
            r_reg_we   <= (w_state_d == CTL_WB);
            if (w_state_d != CTL_WB)        r_wb_sel <= WB_SEL_ALU;
            else if (w_cls_d == CLS_LB)     r_wb_sel <= WB_SEL_MEM;
            else if (w_cls_d == CLS_CPYPC)  r_wb_sel <= WB_SEL_PC;
            else                            r_wb_sel <= WB_SEL_ALU;
            if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    assign imem_req = r_imem_req;
    assign ir_load  = (r_state == CTL_FETCH) && imem_ack;
    assign pc_inc   = (r_state == CTL_FETCH) && imem_ack;
    assign exec_en  = (r_state == CTL_EXEC) && (w_is_alu || w_is_cpypc);
    assign pc_load  = (r_state == CTL_EXEC) && (w_is_jmpadr || w_is_jmpi || w_taken);
    assign pc_sel   = (r_state == CTL_EXEC) && (w_is_jmpi || w_taken);
    assign dmem_req = r_dmem_req;
    assign dmem_we  = r_dmem_we;
    assign reg_we   = r_reg_we;
    assign wb_sel   = r_wb_sel;
    assign state_o  = r_state;
    assign retired  = r_retired;

endmodule
